// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions for the TX and RX controllers.
//               Provides the frame state encoding, the parity mode constants
//               and the default bit period.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // 50 MHz system clock / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Bit-period counter. Counts 0 .. CLKS_PER_BIT-1 and emits a
//               one-cycle tick on the last clock of every bit period. A clear
//               restarts the period so the next clock is count 0.
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous active-low reset
//               clear    - restart the bit period
//               tick     - high on the last clock of a bit period
//               tick_pre - high one clock before tick, lets users register
//                          end-of-bit flags that must line up with tick
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic tick_pre
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick     = (cnt == CNT_LAST);
    assign tick_pre = (cnt == CNT_PRE);

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit sequencer. Accepts a word over valid/ready and
//               sends start bit, data LSB-first, optional parity and one or
//               two stop bits on a registered serial line.
// Ports       : clk       - system clock, rising edge
//               rst       - asynchronous active-low reset
//               tx_data   - word to send, captured on acceptance
//               tx_valid  - requester has a word
//               tx_ready  - block can accept (idle or final stop clock)
//               tx_serial - serial line, idles high
//               busy      - frame in progress
//               tx_done   - pulse on the last clock of the final stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int               IDX_W    = $clog2(DATA_BITS) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             PAR_INV  = (PARITY == PAR_ODD);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift;
    logic [IDX_W-1:0]     bit_idx;
    logic                 parity_acc;
    logic                 stop_cnt;

    logic tick;
    logic tick_pre;
    logic last_stop;
    logic accept;

    // With a single stop bit every stop bit is the last one
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt;

    // Ready opens in the final stop clock so a waiting word starts with no gap
    assign tx_ready = (state == ST_IDLE) ||
                      ((state == ST_STOP) && last_stop && tick);
    assign accept   = tx_valid && tx_ready;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .tick     (tick),
        .tick_pre (tick_pre)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            parity_acc <= 1'b0;
            stop_cnt   <= 1'b0;
            tx_serial  <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            if (accept) begin
                // Covers both the idle start and the back-to-back restart
                state      <= ST_START;
                shift      <= tx_data;
                parity_acc <= ^tx_data;
                bit_idx    <= '0;
                stop_cnt   <= 1'b0;
                tx_serial  <= 1'b0;
                busy       <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        tx_serial <= 1'b1;
                        busy      <= 1'b0;
                    end

                    ST_START: begin
                        if (tick) begin
                            state     <= ST_DATA;
                            bit_idx   <= '0;
                            tx_serial <= shift[0];
                        end
                    end

                    ST_DATA: begin
                        if (tick) begin
                            shift   <= {1'b0, shift[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == IDX_LAST) begin
                                if (PARITY != PAR_NONE) begin
                                    state     <= ST_PARITY;
                                    tx_serial <= parity_acc ^ PAR_INV;
                                end else begin
                                    state     <= ST_STOP;
                                    stop_cnt  <= 1'b0;
                                    tx_serial <= 1'b1;
                                end
                            end else begin
                                // Next bit is the one about to shift into [0]
                                tx_serial <= shift[1];
                            end
                        end
                    end

                    ST_PARITY: begin
                        if (tick) begin
                            state     <= ST_STOP;
                            stop_cnt  <= 1'b0;
                            tx_serial <= 1'b1;
                        end
                    end

                    ST_STOP: begin
                        tx_serial <= 1'b1;
                        // Registered one clock early so it lands on the last clock
                        if (tick_pre && last_stop) begin
                            tx_done <= 1'b1;
                        end
                        if (tick) begin
                            if (!last_stop) begin
                                stop_cnt <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        state     <= ST_IDLE;
                        tx_serial <= 1'b1;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : uart_tx_ctrl
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Self-checking bench for uart_tx_ctrl. Four instances cover
//               no parity, even parity, odd parity and two stop bits, all at
//               4 clocks per bit and 8 data bits.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       valid_v  [4];
    logic [7:0] data_v   [4];
    logic       ready_v  [4];
    logic       serial_v [4];
    logic       busy_v   [4];
    logic       done_v   [4];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_none (
        .clk(clk), .rst(rst), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
        .tx_ready(ready_v[0]), .tx_serial(serial_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
        .tx_ready(ready_v[1]), .tx_serial(serial_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
        .tx_ready(ready_v[2]), .tx_serial(serial_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_two (
        .clk(clk), .rst(rst), .tx_data(data_v[3]), .tx_valid(valid_v[3]),
        .tx_ready(ready_v[3]), .tx_serial(serial_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

    // One frame request: which instance, the word, the hand-computed parity
    // bit, stop count, and flags for the multi-frame corner cases
    typedef struct {
        int       dut;
        logic [7:0] data;
        bit       par_en;
        bit       par_bit;
        int       stops;
        bit       hold;     // keep valid high for a back-to-back follower
        bit       chained;  // accepted in the previous frame's final clock
        bit       poke;     // pulse valid with 0xFF while busy
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected line bits in send order, bit 0 = start bit
    function automatic logic [11:0] build(input logic [7:0] dd, input bit pe, input bit pb,
                                          input int stops, output int n);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = dd;
        n      = 9;
        if (pe) begin
            f[9] = pb;
            n    = 10;
        end
        n = n + stops;
        return f;
    endfunction

    // Called just after the acceptance edge; samples every clock of the frame
    task automatic check_frame(input int d, input logic [11:0] f, input int n,
                               input bit hold, input bit poke, input string tag);
        logic [11:0] bit_bad;
        int          done_err;
        int          ready_err;
        int          busy_err;
        int          last;
        bit_bad   = '0;
        done_err  = 0;
        ready_err = 0;
        busy_err  = 0;
        last      = n * CPB - 1;
        for (int j = 0; j <= last; j++) begin
            @(negedge clk);
            if (serial_v[d] !== f[j / CPB]) bit_bad[j / CPB] = 1'b1;
            if (done_v[d]  !== (j == last)) done_err++;
            if (ready_v[d] !== (j == last)) ready_err++;
            if (busy_v[d]  !== 1'b1)        busy_err++;
            if (j == 0) begin
                data_v[d]  = ~data_v[d];
                valid_v[d] = hold;
            end
            if (poke) valid_v[d] = (j >= 8 && j < 24) ? 1'(j % 2) : 1'b0;
        end
        for (int b = 0; b < n; b++)
            chk($sformatf("%s line bit %0d", tag, b), {15'd0, bit_bad[b]}, 16'd0);
        chk($sformatf("%s tx_done misplaced clocks", tag), 16'(done_err), 16'd0);
        chk($sformatf("%s tx_ready misplaced clocks", tag), 16'(ready_err), 16'd0);
        chk($sformatf("%s busy low clocks", tag), 16'(busy_err), 16'd0);
    endtask

    initial begin
        logic [11:0] f;
        int          n;
        int          d;

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_v[i] = 1'b0;
            data_v[i]  = 8'h00;
        end

        vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1, 8'h07, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2, 8'h07, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{3, 8'h55, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{3, 8'hAA, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{2, 8'hFF, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset dut%0d serial", i), {15'd0, serial_v[i]}, 16'd1);
            chk($sformatf("reset dut%0d ready", i),  {15'd0, ready_v[i]},  16'd1);
            chk($sformatf("reset dut%0d busy", i),   {15'd0, busy_v[i]},   16'd0);
            chk($sformatf("reset dut%0d done", i),   {15'd0, done_v[i]},   16'd0);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            d = vecs[v].dut;
            f = build(vecs[v].data, vecs[v].par_en, vecs[v].par_bit, vecs[v].stops, n);
            if (!vecs[v].chained) begin
                @(negedge clk);
                chk($sformatf("vec%0d ready before send", v), {15'd0, ready_v[d]}, 16'd1);
                valid_v[d] = 1'b1;
                data_v[d]  = vecs[v].data;
            end
            @(posedge clk);
            check_frame(d, f, n, vecs[v].hold, vecs[v].poke, $sformatf("vec%0d", v));
            if (!vecs[v].hold) begin
                @(negedge clk);
                chk($sformatf("vec%0d idle serial", v), {15'd0, serial_v[d]}, 16'd1);
                chk($sformatf("vec%0d idle busy", v),   {15'd0, busy_v[d]},   16'd0);
                chk($sformatf("vec%0d idle ready", v),  {15'd0, ready_v[d]},  16'd1);
            end
        end

        // Reset during data bit 3 (line bit 4, clocks 16..19) of a 0x81 frame
        @(negedge clk);
        valid_v[0] = 1'b1;
        data_v[0]  = 8'h81;
        @(posedge clk);
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre-reset line is data bit 3", {15'd0, serial_v[0]}, 16'd0);
        #1 rst = 1'b0;
        #1;
        chk("async reset serial", {15'd0, serial_v[0]}, 16'd1);
        chk("async reset ready",  {15'd0, ready_v[0]},  16'd1);
        chk("async reset busy",   {15'd0, busy_v[0]},   16'd0);
        chk("async reset done",   {15'd0, done_v[0]},   16'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("held reset done", {15'd0, done_v[0]}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post-reset ready", {15'd0, ready_v[0]}, 16'd1);
        chk("post-reset serial", {15'd0, serial_v[0]}, 16'd1);
        valid_v[0] = 1'b1;
        data_v[0]  = 8'h3C;
        @(posedge clk);
        f = build(8'h3C, 1'b0, 1'b0, 1, n);
        check_frame(0, f, n, 1'b0, 1'b0, "after reset 0x3C");
        @(negedge clk);
        chk("after reset idle serial", {15'd0, serial_v[0]}, 16'd1);
        chk("after reset idle busy",   {15'd0, busy_v[0]},   16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_tx_ctrl
`default_nettype wire
